da2_spi: RTL and testbench

Continuous-update SPI transmitter for the PmodDA2 (two DAC121S101 12-bit DACs sharing SYNC and SCLK, separate data lines). It sits between a fabric-side sample source (AXI-stream-like valid/ready) and the Pmod pins. It is the output-direction counterpart of the AD1 polling receiver and uses the same bit-period / porch parameter scheme. Each accepted sample pair becomes one 16-bit frame, sent MSB first on both lines simultaneously.

---
 rtl/da2_pkg.sv | 26 ++
 rtl/da2_spi_if.sv | 14 +
 rtl/spi_bit_timer.sv | 38 +++
 rtl/da2_spi.sv | 142 ++++++++++++++
 tb/tb_da2_spi.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/da2_pkg.sv
// Shared types and constants for the PmodDA2 SPI transmitter.
package da2_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_BITS  = 12;

  // Power-down field carried in bits 13:12 of every frame.
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRONT_PORCH,
    S_SHIFTING,
    S_BACK_PORCH
  } state_e;

  // DAC121S101 frame: two don't-care zeros, power-down mode, 12-bit code.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0]           pd,
                                                         input logic [DATA_BITS-1:0] data);
    return {2'b00, pd, data};
  endfunction

endpackage

// File: rtl/da2_spi_if.sv
// Sample-side valid/ready stream feeding the DA2 transmitter.
interface da2_spi_if;
  import da2_pkg::*;

  logic [DATA_BITS-1:0] din0;
  logic [DATA_BITS-1:0] din1;
  logic [1:0]           pd;
  logic                 valid;
  logic                 ready;

  modport master (output din0, output din1, output pd, output valid, input ready);
  modport slave  (input din0, input din1, input pd, input valid, output ready);

endinterface

// File: rtl/spi_bit_timer.sv
// Bit-period counter for Pmod SPI masters: SCLK high for the first half of each period,
// low for the second half, plus a strobe on the last cycle of the period.
module spi_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk_lvl,
  output logic bit_end
);

  localparam int unsigned CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Period decode; an idle timer holds count 0 so SCLK reads high.
  always_comb begin
    bit_end  = en && (cnt_q == CW'(CLOCKS_PER_BIT - 1));
    sclk_lvl = (cnt_q < CW'(CLOCKS_PER_BIT / 2));
    cnt_d    = cnt_q;
    if (!en || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/da2_spi.sv
// Continuous-update SPI transmitter for the PmodDA2 (two DAC121S101 sharing SYNC/SCLK).
// Pins and done are registered copies of the state decode, so they trail the FSM by one
// cycle: accept on edge T puts SYNC low from edge T+1.
module da2_spi
  import da2_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT     = 20,
  parameter int unsigned CLOCKS_BEFORE_DATA = 2,
  parameter int unsigned CLOCKS_AFTER_DATA  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  da2_spi_if.slave      s,
  output logic          done,
  output logic          sync,
  output logic          sclk,
  output logic          sdout0,
  output logic          sdout1
);

  localparam int unsigned PORCH_MAX = (CLOCKS_BEFORE_DATA > CLOCKS_AFTER_DATA) ?
                                      CLOCKS_BEFORE_DATA : CLOCKS_AFTER_DATA;
  localparam int unsigned PW = (PORCH_MAX > 1) ? $clog2(PORCH_MAX) : 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         porch_cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [FRAME_BITS-1:0] shift0_q, shift1_q;
  logic                  ready_q;
  logic                  accept;
  logic                  sclk_lvl, bit_end;
  logic                  sync_d, sclk_d, sd0_d, sd1_d, done_d;

  assign accept  = s.valid && ready_q;
  assign s.ready = ready_q;

  spi_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == S_SHIFTING),
    .sclk_lvl(sclk_lvl),
    .bit_end (bit_end)
  );

  // State register; ready is registered from the next state so it stays low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (accept) state_d = S_FRONT_PORCH;
      S_FRONT_PORCH: if (porch_cnt_q == PW'(CLOCKS_BEFORE_DATA - 1)) state_d = S_SHIFTING;
      S_SHIFTING:    if (bit_end && (bit_cnt_q == 4'd15)) state_d = S_BACK_PORCH;
      S_BACK_PORCH:  if (porch_cnt_q == PW'(CLOCKS_AFTER_DATA - 1)) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Porch/bit counters and the two frame shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      porch_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift0_q    <= '0;
      shift1_q    <= '0;
    end else begin
      if (state_d != state_q) begin
        porch_cnt_q <= '0;
      end else if ((state_q == S_FRONT_PORCH) || (state_q == S_BACK_PORCH)) begin
        porch_cnt_q <= porch_cnt_q + 1'b1;
      end

      if (state_q != S_SHIFTING) begin
        bit_cnt_q <= '0;
      end else if (bit_end) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (accept) begin
        shift0_q <= build_frame(s.pd, s.din0);
        shift1_q <= build_frame(s.pd, s.din1);
      end else if (bit_end) begin
        shift0_q <= {shift0_q[FRAME_BITS-2:0], 1'b0};
        shift1_q <= {shift1_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // Pin decode from the current state; done marks the first back-porch cycle.
  always_comb begin
    sync_d = 1'b1;
    sclk_d = 1'b1;
    sd0_d  = 1'b0;
    sd1_d  = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FRONT_PORCH: begin
        sync_d = 1'b0;
        sd0_d  = shift0_q[FRAME_BITS-1];
        sd1_d  = shift1_q[FRAME_BITS-1];
      end
      S_SHIFTING: begin
        sync_d = 1'b0;
        sclk_d = sclk_lvl;
        sd0_d  = shift0_q[FRAME_BITS-1];
        sd1_d  = shift1_q[FRAME_BITS-1];
      end
      S_BACK_PORCH: done_d = (porch_cnt_q == '0);
      default: ;
    endcase
  end

  // Output flops: glitch-free pins that return to idle immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 1'b1;
      sclk   <= 1'b1;
      sdout0 <= 1'b0;
      sdout1 <= 1'b0;
      done   <= 1'b0;
    end else begin
      sync   <= sync_d;
      sclk   <= sclk_d;
      sdout0 <= sd0_d;
      sdout1 <= sd1_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_da2_spi.sv
// Self-checking bench for da2_spi: table of frames, streaming, mid-frame reset.
module tb_da2_spi;
  import da2_pkg::*;

  localparam int unsigned CPB = 4;
  localparam int unsigned CBD = 2;
  localparam int unsigned CAD = 3;
  localparam int DONE_LAT = 67;   // accept edge to done: 1 + 2 + 16*4
  localparam int ACC_GAP  = 70;   // accept-to-accept: 67 + 3

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done, sync, sclk, sd0, sd1;

  da2_spi_if bus ();

  da2_spi #(
    .CLOCKS_PER_BIT    (CPB),
    .CLOCKS_BEFORE_DATA(CBD),
    .CLOCKS_AFTER_DATA (CAD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus),
    .done  (done),
    .sync  (sync),
    .sclk  (sclk),
    .sdout0(sd0),
    .sdout1(sd1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] f0;
    logic [15:0] f1;
    int          acc;
  } exp_t;

  typedef struct {
    logic [11:0] d0;
    logic [11:0] d1;
    logic [1:0]  pd;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  vec_t vecs[4];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: collect bits on falling SCLK while SYNC is low, score at each done.
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;
  logic        prev_done = 1'b0;
  logic [15:0] rx0 = '0;
  logic [15:0] rx1 = '0;
  int          nfall = 0;
  int          rise_cyc = -1;
  bit          stream_mode = 1'b0;

  always @(negedge clk) begin
    if (prev_sync && !sync) begin
      rx0   = '0;
      rx1   = '0;
      nfall = 0;
      // high time = back porch plus the accept cycle
      if (stream_mode && rise_cyc >= 0) chk("sync_gap", cyc - rise_cyc, CAD + 1);
    end
    if (!prev_sync && sync) rise_cyc = cyc;
    if (!sync && prev_sclk && !sclk) begin
      rx0 = {rx0[14:0], sd0};
      rx1 = {rx1[14:0], sd1};
      nfall++;
    end
    if (done) begin
      chk("done_width", prev_done, 1'b0);
      chk("done_sync_high", sync, 1'b1);
      chk("ready_low_at_done", bus.ready, 1'b0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no frame pending (cycle %0d)", cyc);
      end else begin
        cur = sb.pop_front();
        chk("sdout0_frame", rx0, cur.f0);
        chk("sdout1_frame", rx1, cur.f1);
        chk("falling_edges", nfall, 16);
        chk("done_latency", cyc - cur.acc, DONE_LAT);
      end
    end
    prev_sclk = sclk;
    prev_sync = sync;
    prev_done = done;
  end

  // Present one sample pair, push its expected frames on accept, then scramble inputs.
  task automatic send(input logic [11:0] d0, input logic [11:0] d1, input logic [1:0] p,
                      input logic [15:0] e0, input logic [15:0] e1);
    int   n;
    exp_t e;
    @(posedge clk);
    #1;
    bus.din0  = d0;
    bus.din1  = d1;
    bus.pd    = p;
    bus.valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 200);
    if (!bus.ready) fail_now("accept");
    e.f0  = e0;
    e.f1  = e1;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.din0  = ~d0;
    bus.din1  = ~d1;
    bus.pd    = ~p;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("frame_done");
      sb.delete();
    end
    repeat (CAD + 2) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sync"}, sync, 1'b1);
    chk({tag, "_sclk"}, sclk, 1'b1);
    chk({tag, "_sdout0"}, sd0, 1'b0);
    chk({tag, "_sdout1"}, sd1, 1'b0);
    chk({tag, "_ready"}, bus.ready, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          acc;
    int          last_acc;
    int          n;
    logic [11:0] sd0_val;
    exp_t        e;

    vecs[0] = '{12'hA5C, 12'h3F0, PD_NORMAL, 16'h0A5C, 16'h03F0};
    vecs[1] = '{12'hFFF, 12'h000, PD_HIZ,    16'h3FFF, 16'h3000};
    vecs[2] = '{12'h123, 12'hABC, PD_1K,     16'h1123, 16'h1ABC};
    vecs[3] = '{12'h800, 12'h7FF, PD_100K,   16'h2800, 16'h27FF};

    bus.din0  = '0;
    bus.din1  = '0;
    bus.pd    = '0;
    bus.valid = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sync", sync, 1'b1);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_sdout0", sd0, 1'b0);
    chk("rst_sdout1", sd1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", bus.ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", bus.ready, 1'b1);
    chk("sync_after_release", sync, 1'b1);

    // Table of single frames; inputs change right after each accept.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].d0, vecs[i].d1, vecs[i].pd, vecs[i].e0, vecs[i].e1);
      wait_idle();
      chk_idle("idle");
    end

    // Streaming: valid held high, incrementing din0, frames back to back.
    stream_mode = 1'b1;
    rise_cyc    = -1;
    last_acc    = -1;
    sd0_val     = 12'h100;
    @(posedge clk);
    #1;
    bus.din0  = sd0_val;
    bus.din1  = 12'h555;
    bus.pd    = PD_NORMAL;
    bus.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.ready && n < 200);
      if (!bus.ready) fail_now("stream_accept");
      e.f0  = {4'b0000, sd0_val};
      e.f1  = 16'h0555;
      e.acc = cyc + 1;
      sb.push_back(e);
      if (last_acc >= 0) chk("accept_spacing", e.acc - last_acc, ACC_GAP);
      last_acc = e.acc;
      @(posedge clk);
      #1;
      if (k == 3) begin
        bus.valid = 1'b0;
      end else begin
        sd0_val  = sd0_val + 12'd1;
        bus.din0 = sd0_val;
      end
      @(negedge clk);
      chk("ready_drop", bus.ready, 1'b0);
    end
    wait_idle();
    stream_mode = 1'b0;
    chk_idle("post_stream");

    // Reset in the middle of bit 7.
    send(12'h321, 12'h654, PD_NORMAL, 16'h0321, 16'h0654);
    acc = sb[sb.size() - 1].acc;
    while (cyc < acc + 1 + int'(CBD) + 7 * int'(CPB) + 1) @(negedge clk);
    chk("pre_reset_sync", sync, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sync", sync, 1'b1);
    chk("midrst_sclk", sclk, 1'b1);
    chk("midrst_ready", bus.ready, 1'b0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(vecs[0].d0, vecs[0].d1, vecs[0].pd, vecs[0].e0, vecs[0].e1);
    wait_idle();
    chk_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
